// File: rtl/rv32v_dmem_responder_if.sv
// Request/response bundle between the vector memory stage and its data-memory responder.
// The requester holds ren/wen until dhit; dmemload/derr are only meaningful with dhit.
interface rv32v_dmem_responder_if;
   logic        ren;
   logic        wen;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [3:0]  byte_ena;
   logic [31:0] dmemload;
   logic        dhit;
   logic        derr;

   modport master (
      output ren,
      output wen,
      output dmemaddr,
      output dmemstore,
      output byte_ena,
      input  dmemload,
      input  dhit,
      input  derr
   );

   modport slave (
      input  ren,
      input  wen,
      input  dmemaddr,
      input  dmemstore,
      input  byte_ena,
      output dmemload,
      output dhit,
      output derr
   );
endinterface

// File: rtl/rv32v_dmem_responder.sv
// Word-addressed data-memory responder with fixed hit latency, byte-enable writes and one
// outstanding request; outputs are decoded from state flops only.
module rv32v_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned HIT_LATENCY = 2
) (
   input logic                   CLK,
   input logic                   nRST,
   rv32v_dmem_responder_if.slave dmem
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LAT_M1 = 4'(HIT_LATENCY - 1);
   localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
   typedef enum logic [1:0] {OpRead, OpWrite, OpIllegal} op_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      store_q;
   logic [3:0]       be_q;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [32:0]      offset;
   logic             out_of_range;
   logic [IDX_W-1:0] idx_in;
   logic             req;
   logic             accept;
   logic             unused_offset_bits;

   // Address decode and operation classification of the incoming request
   always_comb begin
      offset             = {1'b0, dmem.dmemaddr} - {1'b0, BASE_ADDR};
      // bit 32 is the borrow, so addr < BASE_ADDR lands here as well
      out_of_range       = |offset[32:IDX_W+2];
      idx_in             = offset[IDX_W+1:2];
      unused_offset_bits = ^offset[1:0];
      req                = dmem.ren | dmem.wen;
      accept             = (state_q == StIdle) && req;
      if ((dmem.ren && dmem.wen) || out_of_range) begin
         op_d = OpIllegal;
      end else if (dmem.wen) begin
         op_d = OpWrite;
      end else begin
         op_d = OpRead;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               cnt_d   = LAT_M1;
               state_d = (HIT_LATENCY == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            if (!req) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode
   always_comb begin
      dmem.dhit     = (state_q == StResp);
      dmem.derr     = 1'b0;
      dmem.dmemload = '0;
      if (state_q == StResp) begin
         unique case (op_q)
            OpRead:    dmem.dmemload = mem[idx_q];
            OpIllegal: begin
               dmem.dmemload = ERR_DATA;
               dmem.derr     = 1'b1;
            end
            default:   dmem.dmemload = '0;
         endcase
      end
   end

   // Latched request; later input changes do not disturb it
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         op_q    <= OpRead;
         idx_q   <= '0;
         store_q <= '0;
         be_q    <= '0;
      end else if (accept) begin
         op_q    <= op_d;
         idx_q   <= idx_in;
         store_q <= dmem.dmemstore;
         be_q    <= dmem.byte_ena;
      end
   end

   // Backing store is not reset; writes commit on the edge that ends the response cycle
   always_ff @(posedge CLK) begin
      if (state_q == StResp && op_q == OpWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[idx_q][8*i +: 8] <= store_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32v_dmem_responder.sv
// Scoreboard bench for rv32v_dmem_responder: one instance at HIT_LATENCY=2, one at 1,
// sharing a requester that is steered to one of them by sel.
module tb_rv32v_dmem_responder;

   localparam int unsigned DEPTH = 1024;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   rv32v_dmem_responder_if bus_a ();
   rv32v_dmem_responder_if bus_b ();

   logic        sel;
   logic        ren, wen;
   logic [31:0] addr, store;
   logic [3:0]  be;

   assign bus_a.ren       = ren & ~sel;
   assign bus_a.wen       = wen & ~sel;
   assign bus_a.dmemaddr  = addr;
   assign bus_a.dmemstore = store;
   assign bus_a.byte_ena  = be;
   assign bus_b.ren       = ren & sel;
   assign bus_b.wen       = wen & sel;
   assign bus_b.dmemaddr  = addr;
   assign bus_b.dmemstore = store;
   assign bus_b.byte_ena  = be;

   wire        dhit     = sel ? bus_b.dhit : bus_a.dhit;
   wire        derr     = sel ? bus_b.derr : bus_a.derr;
   wire [31:0] dmemload = sel ? bus_b.dmemload : bus_a.dmemload;

   rv32v_dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (32'h0000_0000),
      .HIT_LATENCY(2)
   ) dut_a (
      .CLK (CLK),
      .nRST(nRST),
      .dmem(bus_a)
   );

   rv32v_dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (32'h0000_0000),
      .HIT_LATENCY(1)
   ) dut_b (
      .CLK (CLK),
      .nRST(nRST),
      .dmem(bus_b)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic        chk_data;
      int          at;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model[int];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      ren = r; wen = w; addr = a; store = d; be = b;
   endtask

   // b2b: issued during a response cycle, so the request is seen in the following cycle
   task automatic req(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input bit b2b);
      exp_t e;
      int   key;
      logic illegal;
      key       = (sel ? 65536 : 0) + int'(a[31:2]);
      illegal   = (r && w) || (a >= 32'(4 * DEPTH));
      e.err     = illegal;
      e.chk_data = illegal || r;
      e.data    = illegal ? 32'hBAD0_BAD0 : (r ? model[key] : 32'h0);
      e.at      = (b2b ? cyc + 1 : cyc) + (sel ? 1 : 2);
      if (w && !illegal) model[key] = merge(model.exists(key) ? model[key] : 32'h0, d, b);
      sb.push_back(e);
      drive(r, w, a, d, b);
   endtask

   task automatic wait_resp();
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge CLK);
         if (dhit) begin
            got = 1'b1;
            if (sb.size() == 0) begin
               check("spurious_dhit", 32'(dhit), 32'd0);
            end else begin
               e = sb.pop_front();
               check("dhit_cycle", 32'(cyc), 32'(e.at));
               check("derr", 32'(derr), 32'(e.err));
               if (e.chk_data) check("dmemload", dmemload, e.data);
            end
         end else begin
            check("idle_load", dmemload, 32'h0);
            check("idle_err", 32'(derr), 32'd0);
         end
      end
      if (!got) begin
         check("dhit_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         check("no_dhit", 32'(dhit), 32'd0);
      end
   endtask

   task automatic single(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      req(r, w, a, d, b, 1'b0);
      wait_resp();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(1);
   endtask

   initial begin
      nRST = 1'b0;
      sel  = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("rst_dhit_a", 32'(bus_a.dhit), 32'd0);
      check("rst_derr_a", 32'(bus_a.derr), 32'd0);
      check("rst_load_a", bus_a.dmemload, 32'h0);
      check("rst_dhit_b", 32'(bus_b.dhit), 32'd0);
      check("rst_derr_b", 32'(bus_b.derr), 32'd0);
      check("rst_load_b", bus_b.dmemload, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      idle(1);

      // Latency 2: read latency, byte enables, abort, errors, no-op write, RAW
      single(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
      single(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      single(1'b0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
      single(1'b0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101);
      single(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
      check("be_merge_model", model[2], 32'hFFBB_FFDD);
      single(1'b0, 1'b1, 32'h0C, 32'h0C0C_0C0C, 4'hF);
      drive(1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF);
      @(negedge CLK);
      drive(1'b0, 1'b0, 32'h0C, 32'hDEAD_BEEF, 4'hF);
      idle(4);
      single(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
      single(1'b1, 1'b1, 32'h10, 32'h5555_5555, 4'hF);
      single(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      single(1'b0, 1'b1, 32'(4 * DEPTH), 32'h7777_7777, 4'hF);
      single(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
      single(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
      single(1'b0, 1'b1, 32'h10, 32'h0000_0000, 4'b0000);
      single(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      req(1'b0, 1'b1, 32'h14, 32'h55AA_55AA, 4'hF, 1'b0);
      wait_resp();
      req(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1);
      wait_resp();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(2);

      // Latency 1: back-to-back writes then reads, advancing on each dhit
      sel = 1'b1;
      idle(1);
      req(1'b0, 1'b1, 32'h0, 32'hA000_0000, 4'hF, 1'b0);
      wait_resp();
      for (int i = 1; i < 4; i++) begin
         req(1'b0, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1);
         wait_resp();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(1);
      req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      wait_resp();
      for (int i = 1; i < 4; i++) begin
         req(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1);
         wait_resp();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(2);

      // Reset mid-write discards the pending write
      sel = 1'b0;
      idle(1);
      single(1'b0, 1'b1, 32'h0, 32'h1111_0000, 4'hF);
      drive(1'b0, 1'b1, 32'h0, 32'h0000_0001, 4'hF);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("rst_mid_dhit", 32'(dhit), 32'd0);
      check("rst_mid_load", dmemload, 32'h0);
      @(negedge CLK);
      check("rst_hold_dhit", 32'(dhit), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge CLK);
      nRST = 1'b1;
      idle(1);
      single(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
